// File: rtl/move_scheduler.sv
// Ply sequencer for the all_moves generator: it launches generation, walks every move through the
// evaluator, keeps the best-scoring index for the side to move, then clears the generator.
module move_scheduler #(
  parameter int MAX_POSITIONS_LOG2 = 7,
  parameter int SCORE_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          white_to_move,
  output logic                          gen_board_valid,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  output logic                          eval_start,
  input  logic                          eval_done,
  input  logic signed [SCORE_WIDTH-1:0] eval_score,
  output logic                          busy,
  output logic                          done,
  output logic                          no_moves,
  output logic [MAX_POSITIONS_LOG2-1:0] best_index,
  output logic signed [SCORE_WIDTH-1:0] best_score
);

  localparam int N = MAX_POSITIONS_LOG2;
  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_GEN_WAIT, S_RAM_WAIT, S_EVAL_GO, S_EVAL_WAIT,
    S_NEXT, S_CLEAR, S_CLEAR_WAIT, S_DONE
  } state_t;

  state_t                  state, state_nx;
  logic                    white, white_nx;
  logic                    gen_board_valid_nx, clear_moves_nx, eval_start_nx, done_nx;
  logic                    busy_nx, no_moves_nx;
  logic [N-1:0]            move_index_nx, best_index_nx;
  logic signed [SCORE_WIDTH-1:0] best_score_nx;
  logic [N:0]              next_index;

  function automatic logic better(input logic w,
                                  input logic signed [SCORE_WIDTH-1:0] cand,
                                  input logic signed [SCORE_WIDTH-1:0] best);
    return w ? (cand > best) : (cand < best);
  endfunction

  // One extra bit so the last index of a full 2^N-1 list cannot wrap back to 0.
  assign next_index = {1'b0, move_index} + ONE;

  always_comb begin
    state_nx           = state;
    white_nx           = white;
    gen_board_valid_nx = 1'b0;
    clear_moves_nx     = 1'b0;
    eval_start_nx      = 1'b0;
    done_nx            = 1'b0;
    busy_nx            = busy;
    no_moves_nx        = no_moves;
    move_index_nx      = move_index;
    best_index_nx      = best_index;
    best_score_nx      = best_score;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx           = S_GEN_WAIT;
          gen_board_valid_nx = 1'b1;
          busy_nx            = 1'b1;
          white_nx           = white_to_move;
          no_moves_nx        = 1'b0;
        end
      end
      S_GEN_WAIT: begin
        if (moves_ready) begin
          if (move_count == '0) begin
            no_moves_nx    = 1'b1;
            best_index_nx  = '0;
            best_score_nx  = '0;
            clear_moves_nx = 1'b1;
            state_nx       = S_CLEAR;
          end else begin
            move_index_nx = '0;
            state_nx      = S_RAM_WAIT;
          end
        end
      end
      S_RAM_WAIT: begin
        eval_start_nx = 1'b1;
        state_nx      = S_EVAL_GO;
      end
      S_EVAL_GO: state_nx = S_EVAL_WAIT;
      S_EVAL_WAIT: begin
        if (eval_done) begin
          // Strict comparison means a tie keeps the earlier (lower) index.
          if (move_index == '0 || better(white, eval_score, best_score)) begin
            best_index_nx = move_index;
            best_score_nx = eval_score;
          end
          state_nx = S_NEXT;
        end
      end
      S_NEXT: begin
        if (next_index < {1'b0, move_count}) begin
          move_index_nx = next_index[N-1:0];
          state_nx      = S_RAM_WAIT;
        end else begin
          clear_moves_nx = 1'b1;
          state_nx       = S_CLEAR;
        end
      end
      S_CLEAR:      state_nx = S_CLEAR_WAIT;
      S_CLEAR_WAIT: begin
        done_nx  = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        busy_nx       = 1'b0;
        move_index_nx = '0;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      white           <= 1'b0;
      gen_board_valid <= 1'b0;
      clear_moves     <= 1'b0;
      eval_start      <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      no_moves        <= 1'b0;
      move_index      <= '0;
      best_index      <= '0;
      best_score      <= '0;
    end else begin
      state           <= state_nx;
      white           <= white_nx;
      gen_board_valid <= gen_board_valid_nx;
      clear_moves     <= clear_moves_nx;
      eval_start      <= eval_start_nx;
      done            <= done_nx;
      busy            <= busy_nx;
      no_moves        <= no_moves_nx;
      move_index      <= move_index_nx;
      best_index      <= best_index_nx;
      best_score      <= best_score_nx;
    end
  end

endmodule
